// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory: FSM state encoding,
// default geometry and the NOP fill word.
package instr_mem_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 64;
  localparam logic [31:0] NOP_DEFAULT   = 32'hFC000000;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    PROG = 2'd2
  } state_t;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x WIDTH storage: one synchronous write port, one synchronous read port.
// Contents are intentionally not reset; the owner clears them with a sweep.
module instr_mem_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register only moves on an enabled read so the fetched word holds.
  always_ff @(posedge CLK) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory with an INIT sweep that fills every word with NOP,
// a RUN state serving 1-cycle-latency fetches, and a PROG state for writes.
module instruction_memory
  import instr_mem_pkg::*;
#(
  parameter int unsigned       WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned       DEPTH    = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0]  NOP_WORD = NOP_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FETCH_REQ,
  input  logic [WIDTH-1:0]         ADDRESS,
  input  logic                     STALL,
  input  logic                     PROG_WE,
  input  logic [$clog2(DEPTH)-1:0] PROG_ADDR,
  input  logic [WIDTH-1:0]         PROG_DATA,
  output logic [WIDTH-1:0]         INSTR,
  output logic                     INSTR_VALID,
  output logic                     FAULT,
  output logic                     READY,
  output state_t                   STATE
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t           state, state_n;
  logic [AW-1:0]    cnt;
  logic             cnt_last;
  logic [WIDTH-1:0] word_idx;
  logic             fetch_fault;
  logic             fetch_accept;
  logic             valid_q, fault_q, nop_sel_q;
  logic             arr_we;
  logic [AW-1:0]    arr_waddr;
  logic [WIDTH-1:0] arr_wdata;
  logic [WIDTH-1:0] arr_rdata;

  assign cnt_last    = (cnt == AW'(DEPTH - 1));
  assign word_idx    = ADDRESS >> 2;
  assign fetch_fault = (ADDRESS[1:0] != 2'b00) || (word_idx >= WIDTH'(DEPTH));

  // Fetch handshake: a request is accepted only in RUN when STALL=0 and no
  // program write competes that cycle; the response appears one cycle later
  // with INSTR_VALID=1. READY is the only flow-control signal offered.
  assign fetch_accept = (state == RUN) && FETCH_REQ && !STALL && !PROG_WE;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == INIT) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      INIT:    if (cnt_last) state_n = RUN;
      RUN:     if (PROG_WE) state_n = PROG;
      PROG:    if (!PROG_WE) state_n = RUN;
      default: state_n = INIT;
    endcase
  end

  // The init sweep and program writes share the single write port.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = PROG_ADDR;
    arr_wdata = PROG_DATA;
    if (state == INIT) begin
      arr_we    = 1'b1;
      arr_waddr = cnt;
      arr_wdata = NOP_WORD;
    end else if (PROG_WE) begin
      arr_we = 1'b1;
    end
  end

  instr_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .CLK   (CLK),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (fetch_accept && !fetch_fault),
    .raddr (ADDRESS[AW+1:2]),
    .rdata (arr_rdata)
  );

  // nop_sel_q selects NOP_WORD over the read register, so a reset or a faulted
  // fetch shows NOP without touching the (unreset) storage path.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      nop_sel_q <= 1'b1;
    end else if (!STALL) begin
      if (fetch_accept) begin
        valid_q   <= 1'b1;
        fault_q   <= fetch_fault;
        nop_sel_q <= fetch_fault;
      end else begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
      end
    end
  end

  assign INSTR       = nop_sel_q ? NOP_WORD : arr_rdata;
  assign INSTR_VALID = valid_q;
  assign FAULT       = fault_q;
  assign READY       = (state == RUN);
  assign STATE       = state;

endmodule
